// File: rtl/host_tx_mq_read_control_if.sv
// host_tx_mq_read_control_if: bus between the host scheduler, PCB and the multi-queue read controller
// Descriptor enqueue: iv_pkt_descriptor/iv_desc_qid/i_pkt_descriptor_wr in, ov_desc_ready out.
// PCB cell read:      ov_pkt_raddr/o_pkt_rd out, i_pkt_raddr_ack/i_pkt_rx_valid/i_pkt_last_cycle_rx in.
// Release/downstream: ov_pkt_bufid/o_pkt_bufid_wr/ov_pkt_inport out, i_pkt_bufid_ack/i_pkt_rd_req in.
// Status:             o_desc_drop_pulse, o_len_err_pulse, ov_read_state out.
interface host_tx_mq_read_control_if #(
  parameter int NUM_Q = 4,
  parameter int BUFID_W = 9,
  parameter int INPORT_W = 4,
  parameter int CELL_W = 7
);
  localparam int QW = NUM_Q > 1 ? $clog2(NUM_Q) : 1;
  logic [INPORT_W+BUFID_W-1:0] iv_pkt_descriptor;
  logic [QW-1:0] iv_desc_qid;
  logic i_pkt_descriptor_wr;
  logic [NUM_Q-1:0] ov_desc_ready;
  logic [BUFID_W+CELL_W-1:0] ov_pkt_raddr;
  logic o_pkt_rd;
  logic i_pkt_raddr_ack;
  logic i_pkt_rx_valid;
  logic i_pkt_last_cycle_rx;
  logic i_pkt_rd_req;
  logic [INPORT_W-1:0] ov_pkt_inport;
  logic [BUFID_W-1:0] ov_pkt_bufid;
  logic o_pkt_bufid_wr;
  logic i_pkt_bufid_ack;
  logic o_desc_drop_pulse;
  logic o_len_err_pulse;
  logic [2:0] ov_read_state;
  modport master (
    output iv_pkt_descriptor, iv_desc_qid, i_pkt_descriptor_wr, i_pkt_raddr_ack, i_pkt_rx_valid,
           i_pkt_last_cycle_rx, i_pkt_rd_req, i_pkt_bufid_ack,
    input  ov_desc_ready, ov_pkt_raddr, o_pkt_rd, ov_pkt_inport, ov_pkt_bufid, o_pkt_bufid_wr,
           o_desc_drop_pulse, o_len_err_pulse, ov_read_state
  );
  modport slave (
    input  iv_pkt_descriptor, iv_desc_qid, i_pkt_descriptor_wr, i_pkt_raddr_ack, i_pkt_rx_valid,
           i_pkt_last_cycle_rx, i_pkt_rd_req, i_pkt_bufid_ack,
    output ov_desc_ready, ov_pkt_raddr, o_pkt_rd, ov_pkt_inport, ov_pkt_bufid, o_pkt_bufid_wr,
           o_desc_drop_pulse, o_len_err_pulse, ov_read_state
  );
endinterface

// File: rtl/host_tx_mq_read_control.sv
// host_tx_mq_read_control: per-queue descriptor FIFOs, strict/RR arbitration, cell read and bufid release FSM
// Ports: i_clk, i_rst_n (async active-low), bus (slave modport of host_tx_mq_read_control_if).
module host_tx_mq_read_control #(
  parameter int NUM_Q = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int BUFID_W = 9,
  parameter int INPORT_W = 4,
  parameter int CELL_W = 7,
  parameter int ARB_MODE = 0
) (
  input logic i_clk,
  input logic i_rst_n,
  host_tx_mq_read_control_if.slave bus
);
  localparam int QW = NUM_Q > 1 ? $clog2(NUM_Q) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = INPORT_W + BUFID_W;
  localparam logic [QW:0] NQ = (QW+1)'(NUM_Q);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE = 3'd0, ISSUE = 3'd1, WAIT = 3'd2, RELEASE = 3'd3} state_t;
  logic [DW-1:0] mem_q [NUM_Q][FIFO_DEPTH];
  logic [AW-1:0] wp_q [NUM_Q], wp_d [NUM_Q], rp_q [NUM_Q], rp_d [NUM_Q];
  logic [AW:0] cnt_q [NUM_Q], cnt_d [NUM_Q];
  logic [NUM_Q-1:0] ready_q, ready_d, push, pop;
  logic [QW-1:0] rr_q, rr_d, win;
  logic found, pop_en, wr_ok, drop_q, drop_d, len_err_q, len_err_d;
  logic [BUFID_W-1:0] bufid_q, bufid_d;
  logic [INPORT_W-1:0] inport_q, inport_d;
  logic [CELL_W-1:0] cell_q, cell_d;
  state_t state_q, state_d;
  int idx;
  always_comb begin
    win = '0;
    found = 1'b0;
    idx = 0;
    // RR scans from the pointer, strict priority from queue 0
    for (int i = 0; i < NUM_Q; i++) begin
      idx = ARB_MODE != 0 ? (int'(rr_q) + i) % NUM_Q : i;
      if (!found && cnt_q[idx] != '0) begin
        found = 1'b1;
        win = QW'(idx);
      end
    end
    pop_en = state_q == IDLE && bus.i_pkt_rd_req && found;
    wr_ok = bus.i_pkt_descriptor_wr && {1'b0, bus.iv_desc_qid} < NQ && ready_q[bus.iv_desc_qid];
    drop_d = bus.i_pkt_descriptor_wr && !wr_ok;
    rr_d = (pop_en && ARB_MODE != 0) ? QW'((int'(win) + 1) % NUM_Q) : rr_q;
    for (int q = 0; q < NUM_Q; q++) begin
      push[q] = wr_ok && bus.iv_desc_qid == QW'(q);
      pop[q] = pop_en && win == QW'(q);
      wp_d[q] = wp_q[q] + AW'(push[q]);
      rp_d[q] = rp_q[q] + AW'(pop[q]);
      cnt_d[q] = cnt_q[q] + (AW+1)'(push[q]) - (AW+1)'(pop[q]);
      ready_d[q] = cnt_d[q] != FULL;
    end
  end
  always_comb begin
    state_d = state_q;
    bufid_d = bufid_q;
    inport_d = inport_q;
    cell_d = cell_q;
    len_err_d = 1'b0;
    case (state_q)
      IDLE: if (pop_en) begin
        {inport_d, bufid_d} = mem_q[win][rp_q[win]];
        cell_d = '0;
        state_d = ISSUE;
      end
      ISSUE: if (bus.i_pkt_raddr_ack) begin
        cell_d = cell_q + 1'b1;
        state_d = WAIT;
      end
      // cell_q back at 0 after an increment means the index space ran out without a tail
      WAIT: if (bus.i_pkt_rx_valid) begin
        len_err_d = !bus.i_pkt_last_cycle_rx && cell_q == '0;
        state_d = (bus.i_pkt_last_cycle_rx || cell_q == '0) ? RELEASE : ISSUE;
      end
      RELEASE: if (bus.i_pkt_bufid_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      bufid_q <= '0;
      inport_q <= '0;
      cell_q <= '0;
      rr_q <= '0;
      drop_q <= 1'b0;
      len_err_q <= 1'b0;
      ready_q <= '1;
      wp_q <= '{default: '0};
      rp_q <= '{default: '0};
      cnt_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      bufid_q <= bufid_d;
      inport_q <= inport_d;
      cell_q <= cell_d;
      rr_q <= rr_d;
      drop_q <= drop_d;
      len_err_q <= len_err_d;
      ready_q <= ready_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge i_clk) begin
    for (int q = 0; q < NUM_Q; q++)
      if (push[q]) mem_q[q][wp_q[q]] <= bus.iv_pkt_descriptor;
  end
  assign bus.ov_desc_ready = ready_q;
  assign bus.ov_pkt_raddr = {bufid_q, cell_q};
  assign bus.o_pkt_rd = state_q == ISSUE;
  assign bus.ov_pkt_inport = inport_q;
  assign bus.ov_pkt_bufid = bufid_q;
  assign bus.o_pkt_bufid_wr = state_q == RELEASE;
  assign bus.o_desc_drop_pulse = drop_q;
  assign bus.o_len_err_pulse = len_err_q;
  assign bus.ov_read_state = state_q;
endmodule

// File: tb/tb_host_tx_mq_read_control.sv
// tb_host_tx_mq_read_control: directed checks of enqueue, arbitration, cell reads, release and reset
module tb_host_tx_mq_read_control;
  logic clk = 1'b0, rst_n = 1'b0, use_rr = 1'b0;
  logic [12:0] desc = '0;
  logic [1:0] qid = '0;
  logic wr = 0, ack = 0, rxv = 0, last = 0, rd_req = 0, back = 0;
  logic [3:0] ready, inport;
  logic [15:0] raddr;
  logic [8:0] bufid;
  logic pkt_rd, bufid_wr, drop, len_err;
  logic [2:0] state;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  host_tx_mq_read_control_if b ();
  host_tx_mq_read_control_if br ();
  host_tx_mq_read_control #(.ARB_MODE(0)) u_sp (.i_clk(clk), .i_rst_n(rst_n), .bus(b.slave));
  host_tx_mq_read_control #(.ARB_MODE(1)) u_rr (.i_clk(clk), .i_rst_n(rst_n), .bus(br.slave));
  assign b.iv_pkt_descriptor = use_rr ? '0 : desc;
  assign br.iv_pkt_descriptor = use_rr ? desc : '0;
  assign b.iv_desc_qid = use_rr ? '0 : qid;
  assign br.iv_desc_qid = use_rr ? qid : '0;
  assign b.i_pkt_descriptor_wr = !use_rr && wr;
  assign br.i_pkt_descriptor_wr = use_rr && wr;
  assign b.i_pkt_raddr_ack = !use_rr && ack;
  assign br.i_pkt_raddr_ack = use_rr && ack;
  assign b.i_pkt_rx_valid = !use_rr && rxv;
  assign br.i_pkt_rx_valid = use_rr && rxv;
  assign b.i_pkt_last_cycle_rx = !use_rr && last;
  assign br.i_pkt_last_cycle_rx = use_rr && last;
  assign b.i_pkt_rd_req = !use_rr && rd_req;
  assign br.i_pkt_rd_req = use_rr && rd_req;
  assign b.i_pkt_bufid_ack = !use_rr && back;
  assign br.i_pkt_bufid_ack = use_rr && back;
  assign ready = use_rr ? br.ov_desc_ready : b.ov_desc_ready;
  assign raddr = use_rr ? br.ov_pkt_raddr : b.ov_pkt_raddr;
  assign pkt_rd = use_rr ? br.o_pkt_rd : b.o_pkt_rd;
  assign inport = use_rr ? br.ov_pkt_inport : b.ov_pkt_inport;
  assign bufid = use_rr ? br.ov_pkt_bufid : b.ov_pkt_bufid;
  assign bufid_wr = use_rr ? br.o_pkt_bufid_wr : b.o_pkt_bufid_wr;
  assign drop = use_rr ? br.o_desc_drop_pulse : b.o_desc_drop_pulse;
  assign len_err = use_rr ? br.o_len_err_pulse : b.o_len_err_pulse;
  assign state = use_rr ? br.ov_read_state : b.ov_read_state;

  typedef struct {
    logic [1:0] qid;
    logic [12:0] desc;
    logic wr;
    logic [3:0] ready;
    logic drop;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [1:0] q, input logic [12:0] d);
    qid = q;
    desc = d;
    wr = 1;
    step;
    wr = 0;
  endtask
  task automatic wait_issue;
    for (int i = 0; i < 8 && state != 3'd1; i++) step;
    chk("pop_to_issue", 32'(state), 32'd1);
  endtask
  task automatic serve(input logic [8:0] eb, input logic [3:0] ei);
    rd_req = 1;
    step;
    wait_issue;
    rd_req = 0;
    chk("serve_raddr", 32'(raddr), 32'({eb, 7'd0}));
    chk("serve_inport", 32'(inport), 32'(ei));
    ack = 1;
    step;
    ack = 0;
    rxv = 1;
    last = 1;
    step;
    rxv = 0;
    last = 0;
    chk("serve_bufid", 32'({bufid_wr, bufid}), 32'({1'b1, eb}));
    back = 1;
    step;
    back = 0;
    chk("serve_idle", 32'(state), 32'd0);
  endtask

  initial begin
    int lerr;
    tbl[0] = '{2'd3, {4'h7, 9'd100}, 1'b1, 4'hf, 1'b0};
    tbl[1] = '{2'd0, {4'h1, 9'd10}, 1'b1, 4'hf, 1'b0};
    tbl[2] = '{2'd0, {4'h1, 9'd11}, 1'b1, 4'hf, 1'b0};
    tbl[3] = '{2'd0, {4'h1, 9'd12}, 1'b1, 4'hf, 1'b0};
    tbl[4] = '{2'd0, {4'h1, 9'd13}, 1'b1, 4'hf, 1'b0};
    tbl[5] = '{2'd0, {4'h1, 9'd14}, 1'b1, 4'hf, 1'b0};
    tbl[6] = '{2'd0, {4'h1, 9'd15}, 1'b1, 4'hf, 1'b0};
    tbl[7] = '{2'd0, {4'h1, 9'd16}, 1'b1, 4'hf, 1'b0};
    tbl[8] = '{2'd0, {4'h1, 9'd17}, 1'b1, 4'he, 1'b0};
    tbl[9] = '{2'd0, {4'h1, 9'd99}, 1'b1, 4'he, 1'b1};
    tbl[10] = '{2'd0, 13'd0, 1'b0, 4'he, 1'b0};
    step;
    step;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ready", 32'(ready), 32'hf);
    chk("rst_outs", 32'({pkt_rd, bufid_wr, drop, len_err, raddr}), 32'd0);
    rst_n = 1;
    step;
    // single packet, three cells, tail on the third
    push(2'd1, {4'd2, 9'd5});
    rd_req = 1;
    step;
    rd_req = 0;
    chk("t1_state", 32'(state), 32'd1);
    chk("t1_inport", 32'(inport), 32'd2);
    for (int c = 0; c < 3; c++) begin
      chk("t1_raddr", 32'(raddr), 32'h280 + 32'(c));
      chk("t1_rd", 32'(pkt_rd), 32'd1);
      if (c == 0) begin
        step;
        chk("t1_hold", 32'({pkt_rd, raddr}), 32'h10280);
      end
      ack = 1;
      step;
      ack = 0;
      chk("t1_wait", 32'({pkt_rd, state}), 32'd2);
      rxv = 1;
      last = c == 2;
      step;
      rxv = 0;
      last = 0;
      if (c < 2) chk("t1_reissue", 32'(state), 32'd1);
    end
    chk("t1_release", 32'({bufid_wr, bufid, state}), 32'({1'b1, 9'd5, 3'd3}));
    step;
    chk("t1_rel_hold", 32'(bufid_wr), 32'd1);
    back = 1;
    step;
    back = 0;
    chk("t1_idle", 32'({bufid_wr, state}), 32'd0);
    chk("t1_inport_kept", 32'(inport), 32'd2);
    // fill q0 past full, one entry in q3
    for (int i = 0; i < 11; i++) begin
      qid = tbl[i].qid;
      desc = tbl[i].desc;
      wr = tbl[i].wr;
      step;
      wr = 0;
      chk($sformatf("tbl%0d_ready", i), 32'(ready), 32'(tbl[i].ready));
      chk($sformatf("tbl%0d_drop", i), 32'(drop), 32'(tbl[i].drop));
    end
    // strict priority: all eight q0 entries before q3; the dropped one never appears
    for (int i = 0; i < 8; i++) serve(9'd10 + 9'(i), 4'h1);
    serve(9'd100, 4'h7);
    chk("t3_empty", 32'(ready), 32'hf);
    rd_req = 1;
    step;
    step;
    rd_req = 0;
    chk("t3_no_extra", 32'(state), 32'd0);
    // round robin
    use_rr = 1;
    for (int k = 0; k < 2; k++)
      for (int q = 0; q < 4; q++) push(2'(q), {4'(q), 9'(200 + q * 10 + k)});
    for (int k = 0; k < 2; k++)
      for (int q = 0; q < 4; q++) serve(9'(200 + q * 10 + k), 4'(q));
    use_rr = 0;
    // no tail for 128 cells
    push(2'd1, {4'd3, 9'd7});
    rd_req = 1;
    step;
    wait_issue;
    rd_req = 0;
    lerr = 0;
    for (int c = 0; c < 128; c++) begin
      if (c == 127) chk("t5_raddr127", 32'(raddr), 32'({9'd7, 7'd127}));
      ack = 1;
      step;
      ack = 0;
      rxv = 1;
      step;
      rxv = 0;
      lerr += int'(len_err);
      if (c < 127 && state != 3'd1) chk("t5_reissue", 32'(state), 32'd1);
    end
    chk("t5_len_err", 32'(len_err), 32'd1);
    chk("t5_len_err_cnt", 32'(lerr), 32'd1);
    chk("t5_release", 32'({bufid_wr, bufid}), 32'({1'b1, 9'd7}));
    step;
    chk("t5_pulse_end", 32'(len_err), 32'd0);
    back = 1;
    step;
    back = 0;
    chk("t5_idle", 32'(state), 32'd0);
    // async reset in ISSUE with ack withheld
    push(2'd2, {4'd4, 9'd9});
    push(2'd1, {4'd5, 9'd11});
    rd_req = 1;
    step;
    wait_issue;
    rd_req = 0;
    step;
    #2;
    rst_n = 0;
    #1;
    chk("t6_outs", 32'({pkt_rd, bufid_wr, drop, len_err, raddr}), 32'd0);
    chk("t6_state_inport", 32'({state, inport, bufid}), 32'd0);
    chk("t6_ready", 32'(ready), 32'hf);
    step;
    rst_n = 1;
    rd_req = 1;
    step;
    step;
    step;
    rd_req = 0;
    chk("t6_queues_empty", 32'({pkt_rd, state}), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
